// File: rtl/mem_stage_lsu_pkg.sv
// Shared RV32I pipeline types for the memory stage: the EX/MEM -> MEM/WB stage
// word, the load/store funct3 encodings, the LSU FSM state, and the byte-lane
// helpers used by the LSU. Imported as rv32i_types::* by the other files.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  // LSU sequencing: IDLE accepts/passes instructions, ACCESS waits on memory.
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } lsu_state_t;

  // Decoded control fields carried alongside the instruction.
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       load_regfile;
    logic       dmem_read;
    logic       dmem_write;
    logic [4:0] rd;
  } ControlWord;

  // Datapath values carried alongside the instruction.
  typedef struct packed {
    rv32i_word pc;
    rv32i_word rs1_out;
    rv32i_word rs2_out;
    rv32i_word alu_out;
    rv32i_word data_mdr;
  } DataWord;

  typedef struct packed {
    ControlWord cw;
    DataWord    dw;
  } rv32i_stage;

  // Byte enables for a store at byte offset off within the addressed word.
  function automatic rv32i_mem_wmask wmask_gen(store_funct3_t funct3, logic [1:0] off);
    rv32i_mem_wmask mask;
    case (funct3)
      sb:      mask = 4'b0001 << off;
      sh:      mask = 4'b0011 << off;
      sw:      mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  // Move the addressed bytes of a read word down to bit 0 and extend them.
  function automatic rv32i_word load_fmt(load_funct3_t funct3, logic [1:0] off,
                                         rv32i_word rdata);
    rv32i_word shifted;
    rv32i_word result;
    shifted = rdata >> {off, 3'b000};
    case (funct3)
      lb:      result = {{24{shifted[7]}}, shifted[7:0]};
      lbu:     result = {24'h000000, shifted[7:0]};
      lh:      result = {{16{shifted[15]}}, shifted[15:0]};
      lhu:     result = {16'h0000, shifted[15:0]};
      lw:      result = shifted;
      default: result = '0;
    endcase
    return result;
  endfunction

  // Halfword accesses need an even offset, word accesses offset zero.
  // When both read and write are set the access is treated as a store.
  function automatic logic is_misaligned(logic is_store, logic [2:0] funct3,
                                         logic [1:0] off);
    logic half;
    logic word;
    if (is_store) begin
      half = (store_funct3_t'(funct3) == sh);
      word = (store_funct3_t'(funct3) == sw);
    end else begin
      half = (load_funct3_t'(funct3) == lh) || (load_funct3_t'(funct3) == lhu);
      word = (load_funct3_t'(funct3) == lw);
    end
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load data alignment: shifts the addressed bytes of a memory word down to
// bit 0 and sign/zero-extends per the load funct3. Purely combinational so a
// future cache line-extraction path can reuse it.
module load_align
  import rv32i_types::*;
(
  input  logic [2:0] funct3_i,
  input  logic [1:0] offset_i,
  input  rv32i_word  rdata_i,
  output rv32i_word  data_o
);

  // Offset shift plus extension of the returned memory word.
  always_comb begin
    data_o = load_fmt(load_funct3_t'(funct3_i), offset_i, rdata_i);
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit. Non-memory instructions pass to WB in one
// cycle; a load/store is captured into a hold register, its request is held
// on the data-memory port until dmem_resp, and the formatted result is then
// emitted toward WB. Upstream is stalled while an access is outstanding.
//
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word accesses
// skip memory, pass through in one cycle with their writeback and memory
// enables cleared, and are flagged on misalign_o. Without it the address is
// silently word-aligned and there is no misalign_o port.
module mem_stage_lsu
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  rv32i_stage        ex_mem_i,
  input  logic              ex_mem_valid_i,
  output logic              mem_stall_o,
  output logic [ADDR_W-1:0] dmem_address,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [3:0]        dmem_wmask,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_resp,
  output rv32i_stage        mem_wb_o,
  output logic              mem_wb_valid_o
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign_o
`endif
);

  lsu_state_t     state_q, state_d;
  rv32i_stage     hold_q, hold_d;
  rv32i_stage     mem_wb_q, mem_wb_d;
  logic           mem_wb_valid_q, mem_wb_valid_d;
  rv32i_mem_wmask wmask_q, wmask_d;
  rv32i_word      wdata_q, wdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic           misalign_q, misalign_d;
`endif

  logic       in_mem_op;
  logic       in_misaligned;
  logic [1:0] in_off;
  logic       hold_is_load;
  rv32i_word  load_data;
  logic [31:0] addr_word;

  assign in_off       = ex_mem_i.dw.alu_out[1:0];
  assign in_mem_op    = ex_mem_valid_i &
                        (ex_mem_i.cw.dmem_read | ex_mem_i.cw.dmem_write);
  // A write request wins over a read, so only pure reads return load data.
  assign hold_is_load = hold_q.cw.dmem_read & ~hold_q.cw.dmem_write;

`ifdef LSU_MISALIGN_TRAP_EN
  assign in_misaligned = ALIGN_CHECK && in_mem_op &&
                         is_misaligned(ex_mem_i.cw.dmem_write,
                                       ex_mem_i.cw.funct3, in_off);
`else
  assign in_misaligned = 1'b0;
  // Alignment checking is not compiled in; ALIGN_CHECK has no effect here.
  if (ALIGN_CHECK) begin : g_align_check_unused
  end
`endif

  // The memory side only ever sees word addresses; byte lanes come from the mask.
  assign addr_word    = {hold_q.dw.alu_out[31:2], 2'b00};
  assign dmem_address = addr_word[ADDR_W-1:0];
  assign dmem_wdata   = wdata_q;

  load_align u_load_align (
    .funct3_i (hold_q.cw.funct3),
    .offset_i (hold_q.dw.alu_out[1:0]),
    .rdata_i  (dmem_rdata),
    .data_o   (load_data)
  );

  // Next-state, request and stall decode for the IDLE/ACCESS sequencer.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    state_d        = state_q;
    hold_d         = hold_q;
    wmask_d        = wmask_q;
    wdata_d        = wdata_q;
    mem_wb_d       = mem_wb_q;
    mem_wb_valid_d = 1'b0;
    mem_stall_o    = 1'b0;
    dmem_read      = 1'b0;
    dmem_write     = 1'b0;
    dmem_wmask     = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d     = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (in_mem_op && !in_misaligned) begin
          // Capture the access; the request goes out from the hold register.
          mem_stall_o = 1'b1;
          hold_d      = ex_mem_i;
          wmask_d     = ex_mem_i.cw.dmem_write
                        ? wmask_gen(store_funct3_t'(ex_mem_i.cw.funct3), in_off)
                        : '0;
          wdata_d     = ex_mem_i.dw.rs2_out << {in_off, 3'b000};
          state_d     = ACCESS;
        end else begin
          // Non-memory (or trapped) instruction: straight through to WB.
          mem_wb_d       = ex_mem_i;
          mem_wb_valid_d = ex_mem_valid_i;
`ifdef LSU_MISALIGN_TRAP_EN
          if (in_misaligned) begin
            mem_wb_d.cw.load_regfile = 1'b0;
            mem_wb_d.cw.dmem_read    = 1'b0;
            mem_wb_d.cw.dmem_write   = 1'b0;
          end
          misalign_d = in_misaligned;
`endif
        end
      end

      ACCESS: begin
        // ex_mem_i is ignored here; everything comes from the hold register.
        dmem_write  = hold_q.cw.dmem_write;
        dmem_read   = hold_is_load;
        dmem_wmask  = wmask_q;
        mem_stall_o = ~dmem_resp;
        if (dmem_resp) begin
          mem_wb_d = hold_q;
          if (hold_is_load) begin
            mem_wb_d.dw.data_mdr = load_data;
          end
          mem_wb_valid_d = 1'b1;
          state_d        = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State, hold and MEM/WB registers; reset abandons any outstanding access.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (rst) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      wmask_q        <= '0;
      wdata_q        <= '0;
      mem_wb_q       <= '0;
      mem_wb_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      wmask_q        <= wmask_d;
      wdata_q        <= wdata_d;
      mem_wb_q       <= mem_wb_d;
      mem_wb_valid_q <= mem_wb_valid_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  // Misalignment flag registered alongside mem_wb_valid_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign_o = misalign_q;
`endif

  assign mem_wb_o       = mem_wb_q;
  assign mem_wb_valid_o = mem_wb_valid_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu. An upstream model holds each
// instruction in EX/MEM until the LSU stops stalling, a responder returns
// memory data after a chosen wait, and expected WB words are computed from
// the load/store byte-lane rules with plain arithmetic.
module tb_mem_stage_lsu;
  import rv32i_types::*;

  logic        clk = 1'b0;
  logic        rst;
  rv32i_stage  ex_mem_i;
  logic        ex_mem_valid_i;
  logic        mem_stall_o;
  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  rv32i_stage  mem_wb_o;
  logic        mem_wb_valid_o;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  mem_stage_lsu #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_mem_i       (ex_mem_i),
    .ex_mem_valid_i (ex_mem_valid_i),
    .mem_stall_o    (mem_stall_o),
    .dmem_address   (dmem_address),
    .dmem_read      (dmem_read),
    .dmem_write     (dmem_write),
    .dmem_wmask     (dmem_wmask),
    .dmem_wdata     (dmem_wdata),
    .dmem_rdata     (dmem_rdata),
    .dmem_resp      (dmem_resp),
    .mem_wb_o       (mem_wb_o),
    .mem_wb_valid_o (mem_wb_valid_o)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign_o     (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          wait_cyc;
    logic [31:0] rdata;
  } mem_plan_t;

  int checks = 0;
  int errors = 0;

  rv32i_stage instr_q[$];
  logic       instr_v_q[$];
  mem_plan_t  plan_q[$];

  // Observations from the most recent stream run, for directed checks.
  rv32i_stage  last_wb;
  logic [31:0] last_addr;
  logic [3:0]  last_wmask;
  logic [31:0] last_wdata;
  int          last_stall_cycles;
  int          out_count;
  logic        last_mis;

  // ---------------- reference model ----------------
  function automatic bit model_is_mem(rv32i_stage s, logic v);
    return v && (s.cw.dmem_read || s.cw.dmem_write);
  endfunction

  function automatic bit model_misaligned(rv32i_stage s, logic v);
`ifdef LSU_MISALIGN_TRAP_EN
    int off;
    int f3;
    if (!model_is_mem(s, v)) return 1'b0;
    off = int'(s.dw.alu_out % 4);
    f3  = int'(s.cw.funct3);
    if (s.cw.dmem_write)
      return (f3 == 1 && off % 2 == 1) || (f3 == 2 && off != 0);
    return ((f3 == 1 || f3 == 5) && off % 2 == 1) || (f3 == 2 && off != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_load(int f3, int off, logic [31:0] rdata);
    logic [31:0] s;
    int v;
    s = rdata >> (8 * off);
    case (f3)
      0: begin v = int'(s & 32'hFF);   if (v > 127)   v -= 256;   return v; end
      4: return s & 32'hFF;
      1: begin v = int'(s & 32'hFFFF); if (v > 32767) v -= 65536; return v; end
      5: return s & 32'hFFFF;
      2: return s;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] model_wmask(int f3, int off);
    int m;
    case (f3)
      0: m = 1 << off;
      1: m = (3 << off) & 15;
      2: m = 15;
      default: m = 0;
    endcase
    return 4'(m);
  endfunction

  function automatic rv32i_stage model_pass(rv32i_stage s, logic v);
    rv32i_stage r;
    r = s;
    if (model_misaligned(s, v)) begin
      r.cw.load_regfile = 1'b0;
      r.cw.dmem_read    = 1'b0;
      r.cw.dmem_write   = 1'b0;
    end
    return r;
  endfunction

  // kind: 0 ALU, 1 load, 2 store, 3 read+write, negative = random mix.
  function automatic rv32i_stage rand_instr(int kind);
    rv32i_stage s;
    int k;
    int r;
    s = '0;
    s.cw.funct7   = 7'($urandom);
    s.cw.rd       = 5'($urandom);
    s.dw.pc       = $urandom;
    s.dw.rs1_out  = $urandom;
    s.dw.rs2_out  = $urandom;
    s.dw.alu_out  = $urandom;
    s.dw.data_mdr = $urandom;
    k = kind;
    if (kind < 0) begin
      r = $urandom_range(0, 9);
      k = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
    end
    case (k)
      0: begin
        r = $urandom_range(0, 3);
        s.cw.opcode       = (r == 0) ? op_imm : (r == 1) ? op_reg : (r == 2) ? op_lui : op_br;
        s.cw.funct3       = 3'($urandom);
        s.cw.load_regfile = 1'($urandom);
      end
      1: begin
        s.cw.opcode       = op_load;
        s.cw.dmem_read    = 1'b1;
        s.cw.load_regfile = 1'b1;
        r = $urandom_range(0, 6);
        case (r)
          0: s.cw.funct3 = 3'd0;
          1: s.cw.funct3 = 3'd1;
          2: s.cw.funct3 = 3'd2;
          3: s.cw.funct3 = 3'd4;
          4: s.cw.funct3 = 3'd5;
          5: s.cw.funct3 = 3'd3;
          default: s.cw.funct3 = 3'd6;
        endcase
`ifndef LSU_MISALIGN_TRAP_EN
        if (s.cw.funct3 == 3'd2) s.dw.alu_out[1:0] = 2'b00;
`endif
      end
      2: begin
        s.cw.opcode     = op_store;
        s.cw.dmem_write = 1'b1;
        s.cw.funct3     = 3'($urandom_range(0, 2));
      end
      default: begin
        s.cw.opcode     = op_store;
        s.cw.dmem_read  = 1'b1;
        s.cw.dmem_write = 1'b1;
        s.cw.funct3     = 3'($urandom_range(0, 2));
      end
    endcase
    return s;
  endfunction

  task automatic push(input rv32i_stage s, input logic v);
    instr_q.push_back(s);
    instr_v_q.push_back(v);
  endtask

  // ---------------- stream engine ----------------
  // Runs every queued instruction through the DUT. Called at posedge+1.
  task automatic run_stream(input int budget);
    rv32i_stage cur;
    rv32i_stage exp;
    logic       cur_v;
    int         age;
    int         wait_target;
    logic [31:0] rdata_plan;
    bit         mem;
    bit         resp;
    bit         exp_stall, exp_rd, exp_wr;
    int         off, f3;
    int         cycles;
    mem_plan_t  p;

    out_count = 0;
    cycles    = 0;
    while (instr_q.size() > 0) begin
      cur   = instr_q.pop_front();
      cur_v = instr_v_q.pop_front();
      age   = 0;
      last_stall_cycles = 0;
      wait_target = $urandom_range(0, 3);
      rdata_plan  = $urandom;
      mem = model_is_mem(cur, cur_v) && !model_misaligned(cur, cur_v);
      if (mem && plan_q.size() > 0) begin
        p = plan_q.pop_front();
        wait_target = p.wait_cyc;
        rdata_plan  = p.rdata;
      end
      off = int'(cur.dw.alu_out % 4);
      f3  = int'(cur.cw.funct3);

      forever begin
        resp = 1'b0;
        dmem_rdata = $urandom;
        if (mem && age >= 1 && age == 1 + wait_target) begin
          resp = 1'b1;
          dmem_rdata = rdata_plan;
        end else if (!mem || age == 0) begin
          resp = ($urandom_range(0, 7) == 0);
        end
        dmem_resp = resp;
        if (mem && age >= 1) begin
          ex_mem_i       = rand_instr(-1);
          ex_mem_valid_i = 1'($urandom);
        end else begin
          ex_mem_i       = cur;
          ex_mem_valid_i = cur_v;
        end
        #1;
        exp_stall = mem && !(age >= 1 && resp);
        exp_rd    = mem && age >= 1 && cur.cw.dmem_read && !cur.cw.dmem_write;
        exp_wr    = mem && age >= 1 && cur.cw.dmem_write;
        checks++;
        if (mem_stall_o !== exp_stall) begin
          errors++;
          $display("FAIL stall age=%0d: got %b expected %b", age, mem_stall_o, exp_stall);
        end
        checks++;
        if (dmem_read !== exp_rd || dmem_write !== exp_wr) begin
          errors++;
          $display("FAIL request age=%0d: got rd=%b wr=%b expected rd=%b wr=%b",
                   age, dmem_read, dmem_write, exp_rd, exp_wr);
        end
        if (mem_stall_o) last_stall_cycles++;
        if (exp_rd || exp_wr) begin
          last_addr = dmem_address;
          checks++;
          if (dmem_address !== (cur.dw.alu_out & 32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL address: got %h expected %h", dmem_address,
                     cur.dw.alu_out & 32'hFFFF_FFFC);
          end
        end
        if (exp_wr) begin
          last_wmask = dmem_wmask;
          last_wdata = dmem_wdata;
          checks++;
          if (dmem_wmask !== model_wmask(f3, off) ||
              dmem_wdata !== (cur.dw.rs2_out << (8 * off))) begin
            errors++;
            $display("FAIL store lanes: got mask=%b data=%h expected mask=%b data=%h",
                     dmem_wmask, dmem_wdata, model_wmask(f3, off),
                     cur.dw.rs2_out << (8 * off));
          end
        end

        @(posedge clk);
        #1;
        if (mem_wb_valid_o) begin
          out_count++;
          last_wb = mem_wb_o;
`ifdef LSU_MISALIGN_TRAP_EN
          last_mis = misalign_o;
`else
          last_mis = 1'b0;
`endif
        end
        cycles++;
        if (cycles > budget) begin
          errors++;
          $display("FAIL stream budget: exceeded %0d cycles", budget);
          instr_q.delete();
          instr_v_q.delete();
          break;
        end

        if (!mem) begin
          exp = model_pass(cur, cur_v);
          checks++;
          if (mem_wb_valid_o !== cur_v || mem_wb_o !== exp) begin
            errors++;
            $display("FAIL passthrough: got v=%b wb=%h expected v=%b wb=%h",
                     mem_wb_valid_o, mem_wb_o, cur_v, exp);
          end
`ifdef LSU_MISALIGN_TRAP_EN
          checks++;
          if (misalign_o !== model_misaligned(cur, cur_v)) begin
            errors++;
            $display("FAIL misalign flag: got %b expected %b", misalign_o,
                     model_misaligned(cur, cur_v));
          end
`endif
          break;
        end else if (age >= 1 && resp) begin
          exp = cur;
          if (cur.cw.dmem_read && !cur.cw.dmem_write)
            exp.dw.data_mdr = model_load(f3, off, rdata_plan);
          checks++;
          if (mem_wb_valid_o !== 1'b1 || mem_wb_o !== exp) begin
            errors++;
            $display("FAIL mem result: got v=%b wb=%h expected v=1 wb=%h",
                     mem_wb_valid_o, mem_wb_o, exp);
          end
          break;
        end else begin
          checks++;
          if (mem_wb_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL valid during access age=%0d: got %b expected 0",
                     age, mem_wb_valid_o);
          end
          age++;
        end
      end
    end
    ex_mem_valid_i = 1'b0;
    dmem_resp      = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst            = 1'b1;
    ex_mem_i       = '0;
    ex_mem_valid_i = 1'b0;
    dmem_rdata     = '0;
    dmem_resp      = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (mem_wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset valid: got %b expected 0", mem_wb_valid_o);
    end
    checks++;
    if (mem_wb_o !== '0) begin
      errors++; $display("FAIL reset wb: got %h expected 0", mem_wb_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
      errors++; $display("FAIL reset request: got rd=%b wr=%b expected 0 0", dmem_read, dmem_write);
    end
    checks++;
    if (dmem_wmask !== 4'b0000) begin
      errors++; $display("FAIL reset wmask: got %b expected 0000", dmem_wmask);
    end
    checks++;
    if (mem_stall_o !== 1'b0) begin
      errors++; $display("FAIL reset stall: got %b expected 0", mem_stall_o);
    end
  endtask

  task automatic test_alu_only();
    for (int i = 0; i < 6; i++) push(rand_instr(0), 1'b1);
    run_stream(100);
    checks++;
    if (out_count !== 6) begin
      errors++; $display("FAIL alu count: got %0d expected 6", out_count);
    end
  endtask

  task automatic test_lb();
    rv32i_stage s;
    mem_plan_t p;
    s = rand_instr(1);
    s.cw.funct3 = 3'b000;
    s.dw.alu_out = 32'h0000_1003;
    push(s, 1'b1);
    p.wait_cyc = 3; p.rdata = 32'h80FF_FFFF;
    plan_q.push_back(p);
    run_stream(50);
    checks++;
    if (last_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL lb address: got %h expected 00001000", last_addr);
    end
    checks++;
    if (last_wb.dw.data_mdr !== 32'hFFFF_FF80) begin
      errors++; $display("FAIL lb data: got %h expected ffffff80", last_wb.dw.data_mdr);
    end
    checks++;
    if (last_stall_cycles !== 4) begin
      errors++; $display("FAIL lb stall cycles: got %0d expected 4", last_stall_cycles);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_wb_valid_o !== 1'b0 || out_count !== 1) begin
      errors++; $display("FAIL lb valid pulse: got v=%b count=%0d expected v=0 count=1",
                         mem_wb_valid_o, out_count);
    end
  endtask

  task automatic test_lhu();
    rv32i_stage s;
    mem_plan_t p;
    s = rand_instr(1);
    s.cw.funct3 = 3'b101;
    s.dw.alu_out = 32'h0000_2002;
    push(s, 1'b1);
    p.wait_cyc = 1; p.rdata = 32'hBEEF_1234;
    plan_q.push_back(p);
    run_stream(50);
    checks++;
    if (last_wb.dw.data_mdr !== 32'h0000_BEEF) begin
      errors++; $display("FAIL lhu data: got %h expected 0000beef", last_wb.dw.data_mdr);
    end
  endtask

  task automatic test_sh();
    rv32i_stage s;
    mem_plan_t p;
    s = rand_instr(2);
    s.cw.funct3 = 3'b001;
    s.dw.alu_out = 32'h0000_3002;
    s.dw.rs2_out = 32'h0000_ABCD;
    s.dw.data_mdr = 32'h5555_AAAA;
    push(s, 1'b1);
    p.wait_cyc = 2; p.rdata = $urandom;
    plan_q.push_back(p);
    run_stream(50);
    checks++;
    if (last_wmask !== 4'b1100 || last_wdata !== 32'hABCD_0000) begin
      errors++; $display("FAIL sh lanes: got mask=%b data=%h expected 1100 abcd0000",
                         last_wmask, last_wdata);
    end
    checks++;
    if (last_wb.dw.data_mdr !== 32'h5555_AAAA || last_addr !== 32'h0000_3000) begin
      errors++; $display("FAIL sh result: got mdr=%h addr=%h expected 5555aaaa 00003000",
                         last_wb.dw.data_mdr, last_addr);
    end
  endtask

  task automatic test_back_to_back();
    rv32i_stage s;
    mem_plan_t p;
    s = rand_instr(1); s.cw.funct3 = 3'b010; s.dw.alu_out[1:0] = 2'b00;
    push(s, 1'b1);
    p.wait_cyc = 0; p.rdata = 32'h1234_5678; plan_q.push_back(p);
    s = rand_instr(1); s.cw.funct3 = 3'b100; s.dw.alu_out = 32'h0000_0041;
    push(s, 1'b1);
    p.wait_cyc = 1; p.rdata = 32'hCAFE_D00D; plan_q.push_back(p);
    run_stream(50);
    checks++;
    if (out_count !== 2 || last_wb.dw.data_mdr !== 32'h0000_00D0) begin
      errors++; $display("FAIL back to back: got count=%0d mdr=%h expected 2 000000d0",
                         out_count, last_wb.dw.data_mdr);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) push(rand_instr(-1), ($urandom_range(0, 9) != 0));
    run_stream(2000);
  endtask

  task automatic test_reset_in_access();
    rv32i_stage s;
    s = rand_instr(1);
    s.cw.funct3 = 3'b010;
    s.dw.alu_out = 32'h0000_5000;
    ex_mem_i = s; ex_mem_valid_i = 1'b1; dmem_resp = 1'b0;
    @(posedge clk); #1;
    ex_mem_valid_i = 1'b0;
    #1;
    checks++;
    if (dmem_read !== 1'b1) begin
      errors++; $display("FAIL access before reset: got rd=%b expected 1", dmem_read);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (dmem_read !== 1'b0 || mem_wb_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset in access: got rd=%b v=%b expected 0 0",
                         dmem_read, mem_wb_valid_o);
    end
    dmem_resp = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    checks++;
    if (mem_wb_valid_o !== 1'b0 || dmem_read !== 1'b0 || mem_stall_o !== 1'b0) begin
      errors++; $display("FAIL stale resp: got v=%b rd=%b stall=%b expected 0 0 0",
                         mem_wb_valid_o, dmem_read, mem_stall_o);
    end
    @(posedge clk); #1;
  endtask

`ifdef LSU_MISALIGN_TRAP_EN
  task automatic test_misalign();
    rv32i_stage s;
    s = rand_instr(1);
    s.cw.funct3 = 3'b010;
    s.dw.alu_out = 32'h0000_4001;
    push(s, 1'b1);
    run_stream(20);
    checks++;
    if (out_count !== 1 || last_mis !== 1'b1 || last_wb.cw.load_regfile !== 1'b0) begin
      errors++; $display("FAIL misaligned lw: got count=%0d mis=%b lr=%b expected 1 1 0",
                         out_count, last_mis, last_wb.cw.load_regfile);
    end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu_only();
    test_lb();
    test_lhu();
    test_sh();
    test_back_to_back();
    test_reset_in_access();
`ifdef LSU_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
